addsub_pipe: RTL and testbench

//  Parametrised, pipelined add/subtract unit; successor to the single-register 16-bit subtractor.

---
 rtl/addsub_pkg.sv | 25 ++
 rtl/addsub_pipe_core.sv | 81 ++++++++
 rtl/addsub_pipe.sv | 88 ++++++++
 tb/tb_addsub_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings and the status flag bundle.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_SUB     = 2'b00,
    OP_ADD     = 2'b01,
    OP_RSUB    = 2'b10,
    OP_ABSDIFF = 2'b11
  } op_e;

  // Bit positions of each flag inside a packed flags_t.
  localparam int unsigned FLAG_NEG  = 0;
  localparam int unsigned FLAG_ZERO = 1;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_CB   = 3;
  localparam int unsigned NUM_FLAGS = 4;

  typedef struct packed {
    logic cb;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/addsub_pipe_core.sv
// Combinational add/subtract datapath: WIDTH+1 bit arithmetic, optional saturation and flags.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SAT   = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic             sgn,
  output logic [WIDTH-1:0] res,
  output flags_t           flags
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   uraw;
  logic [WIDTH:0]   sraw;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   mag;
  logic [WIDTH-1:0] raw_res;
  logic             raw_ovf;

  // RSUB is SUB with the operands swapped; x is always the minuend.
  always_comb begin
    x = a;
    y = b;
    if (op == OP_RSUB) begin
      x = b;
      y = a;
    end
  end

  // Zero- and sign-extended versions of the same operation; low WIDTH bits are identical.
  always_comb begin
    if (op == OP_ADD) begin
      uraw = {1'b0, x} + {1'b0, y};
      sraw = {x[WIDTH-1], x} + {y[WIDTH-1], y};
    end else begin
      uraw = {1'b0, x} - {1'b0, y};
      sraw = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    end
  end

  assign diff = sgn ? sraw : uraw;
  assign mag  = diff[WIDTH] ? (~diff + 1'b1) : diff;

  always_comb begin
    flags   = '0;
    raw_res = uraw[WIDTH-1:0];
    raw_ovf = 1'b0;
    if (op == OP_ABSDIFF) begin
      raw_res  = mag[WIDTH-1:0];
      flags.cb = 1'b0;
      // Magnitude above the signed maximum cannot be represented.
      raw_ovf  = sgn & (mag[WIDTH] | mag[WIDTH-1]);
    end else begin
      flags.cb = uraw[WIDTH];
      raw_ovf  = sgn ? (sraw[WIDTH] ^ sraw[WIDTH-1]) : uraw[WIDTH];
    end
    flags.ovf = raw_ovf;

    res = raw_res;
    if ((SAT != 0) && raw_ovf) begin
      if (sgn) begin
        // sraw[WIDTH] is the sign of the exact result; ABSDIFF is never negative.
        res = ((op != OP_ABSDIFF) && sraw[WIDTH]) ? SMIN : SMAX;
      end else begin
        res = (op == OP_ADD) ? '1 : '0;
      end
    end

    flags.zero = (res == '0);
    flags.neg  = sgn & res[WIDTH-1];
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: compute in stage 1, pure delay stages after, valid/ready on both sides.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cb,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned DW   = WIDTH + NUM_FLAGS;
  localparam int          NS   = STAGES;
  localparam int          LAST = STAGES - 1;

  logic             en;
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;
  flags_t           out_flags;
  logic [DW-1:0]    stage_d [STAGES];
  logic [DW-1:0]    stage_q [STAGES];
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_q;

  addsub_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .a     (a),
    .b     (b),
    .op    (op_e'(op)),
    .sgn   (sgn),
    .res   (core_res),
    .flags (core_flags)
  );

  // The whole pipe advances together; only a blocked full output stalls it.
  assign en       = !vld_q[LAST] | out_ready;
  assign in_ready = en;

  always_comb begin
    stage_d[0] = {core_res, core_flags};
    vld_d[0]   = in_valid;
    for (int i = 1; i < NS; i++) begin
      stage_d[i] = stage_q[i-1];
      vld_d[i]   = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < NS; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      for (int i = 0; i < NS; i++) begin
        // The output stage keeps its last result across bubbles.
        if ((i < LAST) || vld_d[i]) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end
  end

  assign out_valid        = vld_q[LAST];
  assign {res, out_flags} = stage_q[LAST];
  assign cb               = out_flags.cb;
  assign ovf              = out_flags.ovf;
  assign zero             = out_flags.zero;
  assign neg              = out_flags.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench: wrapping and saturating instances driven in lockstep against an integer model.
module tb_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        sgn;

  logic        in_ready0, out_valid0, cb0, ovf0, zero0, neg0;
  logic [15:0] res0;
  logic        in_ready1, out_valid1, cb1, ovf1, zero1, neg1;
  logic [15:0] res1;

  typedef struct {
    logic [19:0] e0;
    logic [19:0] e1;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          last_acc;
  bit          held = 0;
  logic [15:0] held_res0;
  logic [15:0] held_res1;

  addsub_pipe #(.WIDTH(16), .STAGES(2), .SAT(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .a         (a),
    .b         (b),
    .op        (op),
    .sgn       (sgn),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .res       (res0),
    .cb        (cb0),
    .ovf       (ovf0),
    .zero      (zero0),
    .neg       (neg0)
  );

  addsub_pipe #(.WIDTH(16), .STAGES(2), .SAT(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .op        (op),
    .sgn       (sgn),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .res       (res1),
    .cb        (cb1),
    .ovf       (ovf1),
    .zero      (zero1),
    .neg       (neg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Exact integer result, then range check, then optional clamp; packed as {res,cb,ovf,zero,neg}.
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic [1:0] mop, input logic msgn, input bit sat);
    longint av, bv, t, lo, hi;
    logic   mcb, movf;
    logic [15:0] r;
    av = msgn ? longint'($signed(ma)) : longint'(ma);
    bv = msgn ? longint'($signed(mb)) : longint'(mb);
    lo = msgn ? -32768 : 0;
    hi = msgn ? 32767 : 65535;
    case (mop)
      2'b00:   begin t = av - bv; mcb = (ma < mb); end
      2'b01:   begin t = av + bv; mcb = ((longint'(ma) + longint'(mb)) > 65535); end
      2'b10:   begin t = bv - av; mcb = (mb < ma); end
      default: begin t = (av > bv) ? av - bv : bv - av; mcb = 1'b0; end
    endcase
    movf = (t < lo) || (t > hi);
    if (sat && movf) t = (t > hi) ? hi : lo;
    r = t[15:0];
    return {r, mcb, movf, (r == 16'h0), msgn & r[15]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshakes before the edge, update the scoreboard, advance to negedge.
  task automatic cycle();
    exp_t e;
    #1;
    if (held) begin
      chk("stall_hold_res0", res0, held_res0);
      chk("stall_hold_res1", res1, held_res1);
      chk("stall_hold_valid", out_valid0, 1);
      held = 0;
    end
    last_acc = 0;
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid0 && !out_ready) begin
        chk("stall_in_ready0", in_ready0, 0);
        chk("stall_in_ready1", in_ready1, 0);
        held      = 1;
        held_res0 = res0;
        held_res1 = res1;
      end
      if (out_valid0 && out_ready) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_wrap", {res0, cb0, ovf0, zero0, neg0}, e.e0);
          chk("out_sat", {res1, cb1, ovf1, zero1, neg1}, e.e1);
          chk("valid_sat", out_valid1, 1);
        end
      end
      if (in_valid && in_ready0) begin
        e.e0 = model(a, b, op, sgn, 0);
        e.e1 = model(a, b, op, sgn, 1);
        exp_q.push_back(e);
        last_acc = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] top,
                          input logic ts);
    int n;
    a = ta; b = tb; op = top; sgn = ts;
    in_valid  = 1;
    out_ready = 1;
    cycle();
    chk("accept", last_acc, 1);
    in_valid = 0;
    n = 1;
    while (!out_valid0 && n < 10) begin
      cycle();
      n++;
    end
    chk("latency", n, 2);
    cycle();
    chk("single_drained", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 6))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'h0001;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic rand_inputs();
    a   = pick();
    b   = pick();
    op  = 2'($urandom_range(0, 3));
    sgn = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    in_valid  = 0;
    out_ready = 1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int idx;
    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic [1:0]  sop [8];
    logic        ssg [8];

    rst = 0; in_valid = 0; out_ready = 1; a = '0; b = '0; op = '0; sgn = 0;
    @(negedge clk);

    // Reset state
    cycle();
    cycle();
    rst = 1;
    #1;
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_res0", res0, 0);
    chk("rst_flags0", {cb0, ovf0, zero0, neg0}, 0);
    chk("rst_res1", res1, 0);
    chk("rst_in_ready0", in_ready0, 1);
    chk("rst_in_ready1", in_ready1, 1);

    // Directed arithmetic cases with latency check
    send_one(16'h000A, 16'h0005, 2'b00, 0);
    send_one(16'h0005, 16'h000C, 2'b00, 0);
    send_one(16'h7FFF, 16'h0001, 2'b01, 1);
    send_one(16'h0001, 16'h8000, 2'b10, 1);
    send_one(16'h0008, 16'h000C, 2'b11, 0);
    send_one(16'h0008, 16'h0008, 2'b11, 0);
    send_one(16'h8000, 16'h7FFF, 2'b11, 1);
    send_one(16'hFFFF, 16'h0001, 2'b01, 0);

    // Eight back-to-back items with a three-cycle output stall in the middle
    for (int i = 0; i < 8; i++) begin
      sa[i] = pick(); sb[i] = pick();
      sop[i] = 2'($urandom_range(0, 3)); ssg[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int k = 0; k < 20 && idx < 8; k++) begin
      a = sa[idx]; b = sb[idx]; op = sop[idx]; sgn = ssg[idx];
      in_valid  = 1;
      out_ready = !(k >= 4 && k < 7);
      cycle();
      if (last_acc) idx++;
    end
    chk("stream_all_accepted", idx, 8);
    drain();

    // Random traffic with random bubbles and back-pressure
    for (int k = 0; k < 500; k++) begin
      rand_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset with two items in flight
    out_ready = 1;
    in_valid  = 1;
    rand_inputs();
    cycle();
    rand_inputs();
    cycle();
    in_valid = 0;
    rst = 0;
    cycle();
    rst = 1;
    #1;
    chk("midrst_out_valid0", out_valid0, 0);
    chk("midrst_out_valid1", out_valid1, 0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("midrst_no_stale", out_valid0, 0);
    end

    // Traffic resumes normally after the mid-stream reset
    send_one(16'h1234, 16'h0234, 2'b00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
